k2_fetch_unit: RTL and testbench
================================

K2_FETCH_UNIT -- requirements
Module: k2_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 4: program address width, which is the program ROM address width.
REQ-002 Parameter INST_W, default 8: instruction width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  pulse; begins continuous fetch from IDLE or HALT.
REQ-006 stop  input  1  pulse; requests halt.
REQ-007 step  input  1  pulse; fetches exactly one instruction (only with K2_FETCH_STEP_EN).
REQ-008 stall  input  1  downstream not ready; hold PC and IR.
REQ-009 jmp_valid  input  1  redirect request from decode/execute.
REQ-010 jmp_addr  input  ADDR_W  redirect target.
REQ-011 inst_in  input  INST_W  combinational program ROM data for address pc.
REQ-012 pc  output  ADDR_W  registered program counter; drives the ROM address.
REQ-013 ir  output  INST_W  registered instruction register.
REQ-014 ir_valid  output  1  ir holds a valid, un-flushed instruction this cycle.
REQ-015 ir_pc  output  ADDR_W  address from which ir was fetched.
REQ-016 state  output  2  FSM state: IDLE=0, RUN=1, STEP=2, HALT=3.

Function
REQ-017 FSM transitions:
- IDLE, start -> RUN.
- IDLE, step -> STEP.
- RUN, stop -> HALT.
- STEP -> IDLE after its single fetch commits.
- HALT, start -> RUN.
- All other combinations hold state.
REQ-018 Fetch-enable condition: fetch is enabled in a cycle when the state is RUN or STEP and stall=0.
REQ-019 On an enabled fetch edge:
- ir <= inst_in, ir_pc <= pc, ir_valid <= 1.
- pc <= pc+1, modulo 2^ADDR_W; wrap 15->0 is silent.
REQ-020 On an edge where fetch is disabled by stall, pc, ir, ir_pc and ir_valid hold their values.
REQ-021 On an edge where the state is IDLE or HALT, pc, ir and ir_pc hold, and ir_valid <= 0.
REQ-022 Fetch latency: one cycle from pc to ir.
REQ-023 Jump handling:
- jmp_valid=1 at an edge in RUN or STEP: pc <= jmp_addr and ir_valid <= 0, flushing the wrong-path instruction.
- The next enabled fetch reads jmp_addr.
REQ-024 Jump priority:
- jmp_valid overrides stall: redirect applies even while stalled.
- jmp_valid is ignored in IDLE and HALT.
REQ-025 Jump in STEP mode: a jump consumes the step; the FSM returns to IDLE with pc = jmp_addr.
REQ-026 Simultaneous inputs:
- start and stop together in IDLE or HALT: start wins.
- start and stop together in RUN: stop wins.
- step while in RUN: ignored.
REQ-027 Stop and the in-flight fetch: the fetch at the stop edge still commits; HALT takes effect the following cycle.
REQ-028 Once in HALT, ir_valid deasserts one cycle after entry.
REQ-029 No combinational path exists from any input to any output.

Reset
REQ-030 While rst=1, regardless of clk: pc=0, ir=0, ir_pc=0, ir_valid=0, state=IDLE.
REQ-031 Reset asserted mid-run or mid-stall discards any pending jump or step.
REQ-032 The first fetch after reset release reads address 0.

Configuration
REQ-033 Macro K2_FETCH_STEP_EN defined: the STEP state and the step input behave per REQ-017 and REQ-025.
REQ-034 Macro K2_FETCH_STEP_EN undefined:
- step is ignored; state never takes value 2.
- Outputs are otherwise identical.

Verification
REQ-035 Reset, then start with the ROM holding word k at address k -> ir = 0,1,2,... on consecutive cycles with ir_valid=1; ir_pc = ir.
REQ-036 Run to pc=15, then continue -> ir=15 with ir_pc=15, then ir=0 with ir_pc=0 (wrap-around).
REQ-037 At pc=5, assert stall for 3 cycles -> pc stays 5 and ir/ir_valid are frozen; fetch resumes at 5.
REQ-038 Assert jmp_valid=1 with jmp_addr=9 while stall=1 at pc=4 -> next cycle pc=9, ir_valid=0; following fetch gives ir_pc=9.
REQ-039 Assert stop at pc=7 -> ir_pc=7 commits, state=HALT, ir_valid=0 next cycle, pc stays 8; start -> fetch resumes at 8.
REQ-040 With K2_FETCH_STEP_EN, assert step from IDLE at pc=2 -> exactly one ir (ir_pc=2), pc=3, state back to IDLE. Without the macro, the same stimulus produces no fetch.

Source files
------------

// File: rtl/k2_fetch_unit.sv
// Purpose: instruction fetch unit (PC, IR and a run/step/halt FSM) for a program ROM.
// Latency: one cycle from pc to ir; the ROM is read combinationally at address pc.
// Backpressure: stall freezes pc/ir/ir_pc/ir_valid; a jump still redirects while stalled.
//
// Optional feature: define K2_FETCH_STEP_EN to enable single-step mode (STEP state, step input).
// Without it, step is ignored and state never reads 2.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   start, stop, step   control pulses (run / halt request / single fetch)
//   stall               downstream not ready; hold fetch state
//   jmp_valid, jmp_addr redirect request and target
//   inst_in             ROM data for address pc
//   pc                  program counter, drives the ROM address
//   ir, ir_valid, ir_pc fetched instruction, valid flag and its source address
//   state               FSM state: IDLE=0, RUN=1, STEP=2, HALT=3
module k2_fetch_unit #(
    parameter int ADDR_W = 4,
    parameter int INST_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    input  logic              stall,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_addr,
    input  logic [INST_W-1:0] inst_in,
    output logic [ADDR_W-1:0] pc,
    output logic [INST_W-1:0] ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] ir_pc,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t cur_st;
    state_t nxt_st;
    logic   step_req;
    logic   active;

`ifdef K2_FETCH_STEP_EN
    assign step_req = step;
`else
    // Single-step mode is compiled out; step is deliberately left unconnected.
    logic step_unused;
    assign step_unused = step;
    assign step_req    = 1'b0;
`endif

    // Fetch/redirect only happen while running or stepping.
    assign active = (cur_st == S_RUN) || (cur_st == S_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_st <= S_IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            S_IDLE: begin
                if (start) begin
                    nxt_st = S_RUN;
                end else if (step_req) begin
                    nxt_st = S_STEP;
                end
            end
            // stop beats a simultaneous start while running.
            S_RUN: begin
                if (stop) begin
                    nxt_st = S_HALT;
                end
            end
            // The step ends when its fetch commits or a jump consumes it.
            S_STEP: begin
                if (jmp_valid || !stall) begin
                    nxt_st = S_IDLE;
                end
            end
            S_HALT: begin
                if (start) begin
                    nxt_st = S_RUN;
                end
            end
            default: nxt_st = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= '0;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else if (active) begin
            if (jmp_valid) begin
                // Redirect flushes the wrong-path instruction; ir/ir_pc keep stale data.
                pc       <= jmp_addr;
                ir_valid <= 1'b0;
            end else if (!stall) begin
                ir       <= inst_in;
                ir_pc    <= pc;
                ir_valid <= 1'b1;
                pc       <= pc + ADDR_W'(1);
            end
        end else begin
            ir_valid <= 1'b0;
        end
    end

    assign state = cur_st;

endmodule

// File: tb/tb_k2_fetch_unit.sv
// Purpose: self-checking bench for k2_fetch_unit using directed vector tables.
// Latency: each vector is driven at the falling edge and checked 1 time unit after the rising edge.
// Backpressure: stall and jump-under-stall cases are part of the vector tables.
module tb_k2_fetch_unit;

    localparam int ADDR_W = 4;
    localparam int INST_W = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic              stop;
    logic              step;
    logic              stall;
    logic              jmp_valid;
    logic [ADDR_W-1:0] jmp_addr;
    logic [INST_W-1:0] inst_in;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] ir;
    logic              ir_valid;
    logic [ADDR_W-1:0] ir_pc;
    logic [1:0]        state;

    logic [INST_W-1:0] rom [16];

    int total;
    int bad;

    typedef struct {
        logic       start;
        logic       stop;
        logic       step;
        logic       stall;
        logic       jv;
        logic [3:0] ja;
        logic [3:0] e_pc;
        logic [7:0] e_ir;
        logic       e_v;
        logic [3:0] e_irpc;
        logic [1:0] e_st;
    } vec_t;

    vec_t vecs[$];
    vec_t svecs[$];

    k2_fetch_unit #(
        .ADDR_W(ADDR_W),
        .INST_W(INST_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .step     (step),
        .stall    (stall),
        .jmp_valid(jmp_valid),
        .jmp_addr (jmp_addr),
        .inst_in  (inst_in),
        .pc       (pc),
        .ir       (ir),
        .ir_valid (ir_valid),
        .ir_pc    (ir_pc),
        .state    (state)
    );

    // Program ROM: word k at address k.
    assign inst_in = rom[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0d want %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input vec_t v);
        check({tag, ".pc"},       idx, int'(pc),       int'(v.e_pc));
        check({tag, ".ir"},       idx, int'(ir),       int'(v.e_ir));
        check({tag, ".ir_valid"}, idx, int'(ir_valid), int'(v.e_v));
        check({tag, ".ir_pc"},    idx, int'(ir_pc),    int'(v.e_irpc));
        check({tag, ".state"},    idx, int'(state),    int'(v.e_st));
    endtask

    function automatic vec_t mk(input logic st, input logic sp, input logic sq, input logic sl,
                                input logic jv, input logic [3:0] ja, input logic [3:0] epc,
                                input logic [7:0] eir, input logic ev, input logic [3:0] eirpc,
                                input logic [1:0] est);
        vec_t v;
        v.start = st; v.stop = sp; v.step = sq; v.stall = sl; v.jv = jv; v.ja = ja;
        v.e_pc = epc; v.e_ir = eir; v.e_v = ev; v.e_irpc = eirpc; v.e_st = est;
        return v;
    endfunction

    task automatic drive_idle();
        start = 0; stop = 0; step = 0; stall = 0; jmp_valid = 0; jmp_addr = '0;
    endtask

    task automatic run_table(input string tag, input vec_t tbl[$]);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            start = tbl[i].start; stop = tbl[i].stop; step = tbl[i].step;
            stall = tbl[i].stall; jmp_valid = tbl[i].jv; jmp_addr = tbl[i].ja;
            @(posedge clk);
            #1;
            check_all(tag, i, tbl[i]);
        end
        @(negedge clk);
        drive_idle();
    endtask

    vec_t zero_v;

    initial begin
        total = 0;
        bad   = 0;
        for (int k = 0; k < 16; k++) rom[k] = INST_W'(k);
        zero_v = mk(0,0,0,0,0,4'd0, 4'd0,8'd0,1'b0,4'd0,2'd0);

        // Main run table: columns are start stop step stall jv ja | pc ir v ir_pc state.
        vecs.push_back(mk(0,0,0,0,0,4'd0,  4'd0, 8'd0, 0,4'd0, 2'd0)); // idle holds
        vecs.push_back(mk(1,0,0,0,0,4'd0,  4'd0, 8'd0, 0,4'd0, 2'd1)); // start, no fetch yet
        vecs.push_back(mk(0,0,0,0,0,4'd0,  4'd1, 8'd0, 1,4'd0, 2'd1)); // first fetch reads 0
        vecs.push_back(mk(0,0,0,0,0,4'd0,  4'd2, 8'd1, 1,4'd1, 2'd1));
        vecs.push_back(mk(0,0,0,0,0,4'd0,  4'd3, 8'd2, 1,4'd2, 2'd1));
        vecs.push_back(mk(0,0,0,0,0,4'd0,  4'd4, 8'd3, 1,4'd3, 2'd1));
        vecs.push_back(mk(0,0,0,0,0,4'd0,  4'd5, 8'd4, 1,4'd4, 2'd1));
        vecs.push_back(mk(0,0,0,0,1,4'd4,  4'd4, 8'd4, 0,4'd4, 2'd1)); // rewind to 4
        vecs.push_back(mk(0,0,0,1,1,4'd9,  4'd9, 8'd4, 0,4'd4, 2'd1)); // jump under stall at pc=4
        vecs.push_back(mk(0,0,0,0,0,4'd0,  4'd10,8'd9, 1,4'd9, 2'd1)); // fetch from jump target
        vecs.push_back(mk(0,0,0,0,1,4'd4,  4'd4, 8'd9, 0,4'd9, 2'd1));
        vecs.push_back(mk(0,0,0,0,0,4'd0,  4'd5, 8'd4, 1,4'd4, 2'd1));
        vecs.push_back(mk(0,0,0,1,0,4'd0,  4'd5, 8'd4, 1,4'd4, 2'd1)); // stall x3 at pc=5
        vecs.push_back(mk(0,0,0,1,0,4'd0,  4'd5, 8'd4, 1,4'd4, 2'd1));
        vecs.push_back(mk(0,0,0,1,0,4'd0,  4'd5, 8'd4, 1,4'd4, 2'd1));
        vecs.push_back(mk(0,0,0,0,0,4'd0,  4'd6, 8'd5, 1,4'd5, 2'd1)); // resumes at 5
        vecs.push_back(mk(0,0,0,0,0,4'd0,  4'd7, 8'd6, 1,4'd6, 2'd1));
        vecs.push_back(mk(0,1,0,0,0,4'd0,  4'd8, 8'd7, 1,4'd7, 2'd3)); // stop at pc=7 commits
        vecs.push_back(mk(0,0,0,0,0,4'd0,  4'd8, 8'd7, 0,4'd7, 2'd3)); // valid drops in HALT
        vecs.push_back(mk(0,0,0,0,1,4'd2,  4'd8, 8'd7, 0,4'd7, 2'd3)); // jump ignored in HALT
        vecs.push_back(mk(0,0,1,0,0,4'd0,  4'd8, 8'd7, 0,4'd7, 2'd3)); // step ignored in HALT
        vecs.push_back(mk(1,1,0,0,0,4'd0,  4'd8, 8'd7, 0,4'd7, 2'd1)); // start wins in HALT
        vecs.push_back(mk(0,0,0,0,0,4'd0,  4'd9, 8'd8, 1,4'd8, 2'd1)); // resumes at 8
        vecs.push_back(mk(0,0,1,0,0,4'd0,  4'd10,8'd9, 1,4'd9, 2'd1)); // step ignored in RUN
        vecs.push_back(mk(1,1,0,0,0,4'd0,  4'd11,8'd10,1,4'd10,2'd3)); // stop wins in RUN
        vecs.push_back(mk(1,0,0,0,0,4'd0,  4'd11,8'd10,0,4'd10,2'd1));
        vecs.push_back(mk(0,0,0,0,1,4'd14, 4'd14,8'd10,0,4'd10,2'd1));
        vecs.push_back(mk(0,0,0,0,0,4'd0,  4'd15,8'd14,1,4'd14,2'd1));
        vecs.push_back(mk(0,0,0,0,0,4'd0,  4'd0, 8'd15,1,4'd15,2'd1)); // pc wraps 15->0
        vecs.push_back(mk(0,0,0,0,0,4'd0,  4'd1, 8'd0, 1,4'd0, 2'd1));

`ifdef K2_FETCH_STEP_EN
        svecs.push_back(mk(0,0,1,0,0,4'd0,  4'd0, 8'd0, 0,4'd0, 2'd2)); // enter STEP
        svecs.push_back(mk(0,0,0,1,0,4'd0,  4'd0, 8'd0, 0,4'd0, 2'd2)); // stalled step waits
        svecs.push_back(mk(0,0,0,0,0,4'd0,  4'd1, 8'd0, 1,4'd0, 2'd0));
        svecs.push_back(mk(0,0,1,0,0,4'd0,  4'd1, 8'd0, 0,4'd0, 2'd2));
        svecs.push_back(mk(0,0,0,0,0,4'd0,  4'd2, 8'd1, 1,4'd1, 2'd0));
        svecs.push_back(mk(0,0,1,0,0,4'd0,  4'd2, 8'd1, 0,4'd1, 2'd2)); // step at pc=2
        svecs.push_back(mk(0,0,0,0,0,4'd0,  4'd3, 8'd2, 1,4'd2, 2'd0));
        svecs.push_back(mk(0,0,0,0,0,4'd0,  4'd3, 8'd2, 0,4'd2, 2'd0)); // exactly one fetch
        svecs.push_back(mk(0,0,1,0,0,4'd0,  4'd3, 8'd2, 0,4'd2, 2'd2));
        svecs.push_back(mk(0,0,0,1,1,4'd12, 4'd12,8'd2, 0,4'd2, 2'd0)); // jump consumes step
        svecs.push_back(mk(0,0,0,0,0,4'd0,  4'd12,8'd2, 0,4'd2, 2'd0));
`else
        svecs.push_back(mk(0,0,1,0,0,4'd0,  4'd0, 8'd0, 0,4'd0, 2'd0)); // step has no effect
        svecs.push_back(mk(0,0,0,1,0,4'd0,  4'd0, 8'd0, 0,4'd0, 2'd0));
        svecs.push_back(mk(0,0,0,0,0,4'd0,  4'd0, 8'd0, 0,4'd0, 2'd0));
        svecs.push_back(mk(0,0,1,0,0,4'd0,  4'd0, 8'd0, 0,4'd0, 2'd0));
        svecs.push_back(mk(0,0,0,0,0,4'd0,  4'd0, 8'd0, 0,4'd0, 2'd0));
        svecs.push_back(mk(0,0,0,1,1,4'd12, 4'd0, 8'd0, 0,4'd0, 2'd0));
`endif

        drive_idle();
        rst = 1'b1;
        #2;
        check_all("reset", 0, zero_v);
        @(negedge clk);
        rst = 1'b0;

        run_table("run", vecs);

        // Reset asserted mid-run with a stalled jump pending clears asynchronously.
        @(negedge clk);
        stall = 1; jmp_valid = 1; jmp_addr = 4'd7;
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 0, zero_v);
        @(posedge clk);
        #1;
        check_all("rst_hold", 0, zero_v);
        @(negedge clk);
        drive_idle();
        rst = 1'b0;

        run_table("step", svecs);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
